bus_scheduler: RTL and testbench
================================

BUS_SCHEDULER -- requirements
Module: bus_scheduler

Interface
REQ-001 Parameter: HOLD_CYCLES, default 2, number of cycles the shared 4-bit bus is driven per transfer (legal 1..15).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  request lines; bit i = source i (0..3) wants the bus.
REQ-005 src_data  input  16  source nibbles; source i at bits [4i+3:4i].
REQ-006 src_dest  input  8  destination codes; source i at bits [2i+1:2i], value 0..3.
REQ-007 gnt  output  4  one-hot grant to the owning source, zero when no owner.
REQ-008 mux_sel  output  2  index of the granted source, for the 4:1 mux.
REQ-009 dmux_sel  output  2  destination code latched from the granted source, for the 1:4 demux.
REQ-010 bus_en  output  1  enable for the mux/demux pair, high only in HOLD.
REQ-011 bus_data  output  4  nibble latched from the granted source.
REQ-012 dest_valid  output  4  one-hot strobe, bit dmux_sel high while bus_en is high.
REQ-013 done  output  1  one-cycle pulse marking the end of a transfer.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, GRANT, HOLD, RELEASE; all outputs are registered.
REQ-016 IDLE: if req != 0 at a rising edge, the scheduler SHALL pick a winner, enter GRANT, and latch mux_sel, dmux_sel, bus_data and gnt on that same edge; if req == 0 it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: search order starts at (last_winner+1) mod 4 and wraps.
REQ-018 GRANT lasts exactly 1 cycle (bus_en=0), then the FSM SHALL enter HOLD.
REQ-019 HOLD lasts exactly HOLD_CYCLES cycles with bus_en=1, dest_valid=one-hot(dmux_sel), and gnt, mux_sel, dmux_sel, bus_data all stable.
REQ-020 RELEASE lasts exactly 1 cycle: gnt=0, bus_en=0, done=1; last_winner updated; then the FSM SHALL return to IDLE.
REQ-021 Latency: req first seen high at edge N gives gnt valid after edge N, bus_en high for edges N+1..N+HOLD_CYCLES, and done high after edge N+HOLD_CYCLES+1.
REQ-022 Minimum spacing between back-to-back transfers SHALL be HOLD_CYCLES+3 cycles; req is sampled only in IDLE.
REQ-023 Dropping req during GRANT/HOLD SHALL NOT abort the transfer; new req bits arriving during a transfer SHALL be ignored until IDLE.
REQ-024 src_data/src_dest changes after the GRANT edge SHALL NOT affect bus_data/dmux_sel.
REQ-025 HOLD counter SHALL be 4 bits; it reloads on GRANT entry and never wraps within a transfer.

Reset
REQ-026 While reset is high: state=IDLE; gnt=0, mux_sel=0, dmux_sel=0, bus_en=0, bus_data=0, dest_valid=0, done=0, busy=0; last_winner=3, so source 0 has first priority.
REQ-027 Reset mid-transfer SHALL abandon the transfer immediately, with no done pulse; the first post-reset arbitration uses the reset priority.

Configuration
REQ-028 Macro BUS_SCHEDULER_STATS_EN defined: the block SHALL add output xfer_count[15:0], reset to 0, incrementing once per done pulse and saturating at 16'hFFFF.
REQ-029 Macro BUS_SCHEDULER_STATS_EN undefined: no xfer_count port or counter; all other behaviour is identical.

Verification
REQ-030 Single request: HOLD_CYCLES=2, req=4'b0100, src_data[11:8]=4'hA, src_dest[5:4]=2'd1 -> gnt=4'b0100, mux_sel=2, dmux_sel=1, bus_data=4'hA; bus_en and dest_valid=4'b0010 for 2 cycles; done 1 cycle later; busy low afterward.
REQ-031 Fairness: req=4'b1111 held for 4 transfers after reset -> grant order 0,1,2,3, then 0 again; every transfer spans 5 cycles.
REQ-032 Wrap-around: after source 3 wins, req=4'b1001 -> source 0 wins.
REQ-033 Mid-transfer changes: req dropped and src_data changed during HOLD -> transfer completes with the original nibble; done=1.
REQ-034 Reset during HOLD -> next cycle all outputs are 0 and no done pulse; then req=4'b1010 -> source 1 wins.
REQ-035 Stats, with BUS_SCHEDULER_STATS_EN defined: 3 transfers -> xfer_count=3; reset -> 0.

Source files
------------

// File: rtl/bus_scheduler_if.sv
// Bundle of the request, mux/demux control and strobe signals of the shared 4-bit bus scheduler.
//   master : the scheduler side (samples requests and source data, drives grants and bus control)
//   slave  : the source/sink side (drives requests and source data, observes grants and bus control)
// Optional macro BUS_SCHEDULER_STATS_EN adds the xfer_count[15:0] transfer counter signal.
interface bus_scheduler_if;
  logic [3:0]  req;         // bit i: source i wants the bus
  logic [15:0] src_data;    // source i nibble at [4i+3:4i]
  logic [7:0]  src_dest;    // source i destination code at [2i+1:2i]
  logic [3:0]  gnt;         // one-hot grant to the owning source
  logic [1:0]  mux_sel;     // granted source index
  logic [1:0]  dmux_sel;    // latched destination code
  logic        bus_en;      // mux/demux enable, high only while holding the bus
  logic [3:0]  bus_data;    // latched nibble
  logic [3:0]  dest_valid;  // one-hot destination strobe
  logic        done;        // end-of-transfer pulse
  logic        busy;        // scheduler not idle
`ifdef BUS_SCHEDULER_STATS_EN
  logic [15:0] xfer_count;  // completed transfers, saturating
`endif

  modport master (
    input  req, src_data, src_dest,
    output gnt, mux_sel, dmux_sel, bus_en, bus_data, dest_valid, done, busy
`ifdef BUS_SCHEDULER_STATS_EN
    , output xfer_count
`endif
  );

  modport slave (
    output req, src_data, src_dest,
    input  gnt, mux_sel, dmux_sel, bus_en, bus_data, dest_valid, done, busy
`ifdef BUS_SCHEDULER_STATS_EN
    , input xfer_count
`endif
  );
endinterface

// File: rtl/bus_scheduler.sv
// Round-robin scheduler for a shared 4-bit bus between four sources and four destinations.
// A transfer runs IDLE -> GRANT (1 cycle) -> HOLD (HOLD_CYCLES cycles) -> RELEASE (1 cycle).
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : bus_scheduler_if.master (requests/source data in; grant, mux/demux control,
//           latched nibble, destination strobe, done and busy out; all outputs registered)
// Parameter HOLD_CYCLES (1..15): cycles the bus is driven per transfer.
// Optional macro BUS_SCHEDULER_STATS_EN adds a saturating 16-bit completed-transfer counter.
module bus_scheduler #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  bus_scheduler_if.master bus
);

  localparam logic [3:0] HoldLoad = 4'(HOLD_CYCLES);

  typedef enum logic [1:0] {StIdle, StGrant, StHold, StRelease} state_e;

  state_e      state_q, state_d;
  logic [1:0]  last_winner_q;
  logic [1:0]  winner;
  logic [1:0]  rr_idx;
  logic        rr_found;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  dest_q, dest_d;
  logic [3:0]  data_q, data_d;
  logic [3:0]  gnt_q, gnt_d;
  logic        bus_en_q, bus_en_d;
  logic [3:0]  dest_valid_q, dest_valid_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    winner   = last_winner_q;
    rr_found = 1'b0;
    rr_idx   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      rr_idx = last_winner_q + 2'(i);
      if (!rr_found && bus.req[rr_idx]) begin
        winner   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  // State register, transfer latches and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      last_winner_q <= 2'd3;
      hold_cnt_q    <= 4'd0;
      sel_q         <= 2'd0;
      dest_q        <= 2'd0;
      data_q        <= 4'd0;
      gnt_q         <= 4'd0;
      bus_en_q      <= 1'b0;
      dest_valid_q  <= 4'd0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      sel_q        <= sel_d;
      dest_q       <= dest_d;
      data_q       <= data_d;
      gnt_q        <= gnt_d;
      bus_en_q     <= bus_en_d;
      dest_valid_q <= dest_valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      if (state_q == StRelease) begin
        last_winner_q <= sel_q;
      end
    end
  end

  // Next state; source data is captured only on the IDLE -> GRANT edge.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    sel_d      = sel_q;
    dest_d     = dest_q;
    data_d     = data_q;
    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          state_d    = StGrant;
          sel_d      = winner;
          dest_d     = bus.src_dest[{winner, 1'b0} +: 2];
          data_d     = bus.src_data[{winner, 2'b00} +: 4];
          hold_cnt_d = HoldLoad;
        end
      end
      StGrant: state_d = StHold;
      StHold: begin
        // Counter counts HoldLoad..1 and stops at 1, so it never wraps.
        if (hold_cnt_q <= 4'd1) begin
          state_d = StRelease;
        end else begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output next-values decoded from the upcoming state so every output is a flop.
  always_comb begin
    gnt_d        = 4'd0;
    bus_en_d     = 1'b0;
    dest_valid_d = 4'd0;
    done_d       = 1'b0;
    busy_d       = (state_d != StIdle);
    unique case (state_d)
      StGrant: gnt_d = 4'b0001 << sel_d;
      StHold: begin
        gnt_d        = 4'b0001 << sel_d;
        bus_en_d     = 1'b1;
        dest_valid_d = 4'b0001 << dest_d;
      end
      StRelease: done_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.gnt        = gnt_q;
  assign bus.mux_sel    = sel_q;
  assign bus.dmux_sel   = dest_q;
  assign bus.bus_en     = bus_en_q;
  assign bus.bus_data   = data_q;
  assign bus.dest_valid = dest_valid_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;

`ifdef BUS_SCHEDULER_STATS_EN
  logic [15:0] xfer_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_count_q <= 16'd0;
    end else if (done_q && (xfer_count_q != 16'hFFFF)) begin
      xfer_count_q <= xfer_count_q + 16'd1;
    end
  end

  assign bus.xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_bus_scheduler.sv
// Directed self-checking bench for bus_scheduler with HOLD_CYCLES = 2.
module tb_bus_scheduler;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bus_scheduler_if bus_if ();

  bus_scheduler #(
    .HOLD_CYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_gnt"}, 16'(bus_if.gnt), 16'h0);
    check_eq({tag, "_bus_en"}, 16'(bus_if.bus_en), 16'h0);
    check_eq({tag, "_dest_valid"}, 16'(bus_if.dest_valid), 16'h0);
    check_eq({tag, "_done"}, 16'(bus_if.done), 16'h0);
    check_eq({tag, "_busy"}, 16'(bus_if.busy), 16'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check_quiet(tag);
    check_eq({tag, "_mux_sel"}, 16'(bus_if.mux_sel), 16'h0);
    check_eq({tag, "_dmux_sel"}, 16'(bus_if.dmux_sel), 16'h0);
    check_eq({tag, "_bus_data"}, 16'(bus_if.bus_data), 16'h0);
  endtask

  // One full transfer expecting source exp_src to win; req is dropped after the grant edge.
  task automatic run_xfer(input logic [3:0] r, input logic [1:0] exp_src, input string tag);
    logic [3:0] oh;
    oh = 4'b0001 << exp_src;
    bus_if.req = r;
    tick();
    check_eq({tag, "_gnt"}, 16'(bus_if.gnt), 16'(oh));
    check_eq({tag, "_mux_sel"}, 16'(bus_if.mux_sel), 16'(exp_src));
    bus_if.req = 4'd0;
    tick();
    check_eq({tag, "_bus_en"}, 16'(bus_if.bus_en), 16'h1);
    tick();
    tick();
    check_eq({tag, "_done"}, 16'(bus_if.done), 16'h1);
    tick();
    check_eq({tag, "_busy_after"}, 16'(bus_if.busy), 16'h0);
  endtask

  initial begin
    reset           = 1'b1;
    bus_if.req      = 4'd0;
    bus_if.src_data = 16'h0;
    bus_if.src_dest = 8'h0;
    tick();
    tick();
    check_all_zero("reset");
`ifdef BUS_SCHEDULER_STATS_EN
    check_eq("reset_xfer_count", bus_if.xfer_count, 16'h0);
`endif
    reset = 1'b0;
    tick();
    check_quiet("idle_no_req");

    // Single request from source 2.
    bus_if.req      = 4'b0100;
    bus_if.src_data = 16'h0A00;
    bus_if.src_dest = 8'h10;
    tick();
    check_eq("single_gnt", 16'(bus_if.gnt), 16'h4);
    check_eq("single_mux_sel", 16'(bus_if.mux_sel), 16'h2);
    check_eq("single_dmux_sel", 16'(bus_if.dmux_sel), 16'h1);
    check_eq("single_bus_data", 16'(bus_if.bus_data), 16'hA);
    check_eq("single_grant_bus_en", 16'(bus_if.bus_en), 16'h0);
    check_eq("single_busy", 16'(bus_if.busy), 16'h1);
    bus_if.req = 4'd0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check_eq("single_hold_bus_en", 16'(bus_if.bus_en), 16'h1);
      check_eq("single_hold_dest_valid", 16'(bus_if.dest_valid), 16'h2);
      check_eq("single_hold_done", 16'(bus_if.done), 16'h0);
    end
    tick();
    check_eq("single_rel_done", 16'(bus_if.done), 16'h1);
    check_eq("single_rel_gnt", 16'(bus_if.gnt), 16'h0);
    check_eq("single_rel_bus_en", 16'(bus_if.bus_en), 16'h0);
    tick();
    check_quiet("single_after");

    // Fairness: all requesting after reset gives 0,1,2,3,0 with 5-cycle spacing.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_if.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (k % 4);
      tick();
      check_eq("fair_gnt", 16'(bus_if.gnt), 16'(oh));
      if (k < 4) begin
        tick();
        tick();
        tick();
        check_eq("fair_done", 16'(bus_if.done), 16'h1);
        tick();
        check_eq("fair_idle_busy", 16'(bus_if.busy), 16'h0);
      end
    end
    bus_if.req = 4'd0;
    for (int c = 0; c < 4; c++) tick();
    check_quiet("fair_end");

    // Wrap-around after source 3 wins.
    run_xfer(4'b1000, 2'd3, "wrap_src3");
    run_xfer(4'b1001, 2'd0, "wrap_src0");

    // Mid-transfer changes must not disturb the latched transfer.
    bus_if.req      = 4'b0010;
    bus_if.src_data = 16'h0050;
    bus_if.src_dest = 8'h0C;
    tick();
    check_eq("mid_gnt", 16'(bus_if.gnt), 16'h2);
    tick();
    bus_if.req      = 4'd0;
    bus_if.src_data = 16'hFFFF;
    bus_if.src_dest = 8'h00;
    tick();
    check_eq("mid_bus_data", 16'(bus_if.bus_data), 16'h5);
    check_eq("mid_dmux_sel", 16'(bus_if.dmux_sel), 16'h3);
    check_eq("mid_dest_valid", 16'(bus_if.dest_valid), 16'h8);
    check_eq("mid_gnt_hold", 16'(bus_if.gnt), 16'h2);
    tick();
    check_eq("mid_done", 16'(bus_if.done), 16'h1);
    check_eq("mid_bus_data_rel", 16'(bus_if.bus_data), 16'h5);
    tick();
    check_quiet("mid_after");

    // Reset during HOLD abandons the transfer without a done pulse.
    bus_if.req = 4'b0001;
    tick();
    bus_if.req = 4'd0;
    tick();
    check_eq("rst_hold_bus_en", 16'(bus_if.bus_en), 16'h1);
    reset = 1'b1;
    tick();
    check_all_zero("rst_mid");
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("rst_no_done", 16'(bus_if.done), 16'h0);
    end
    run_xfer(4'b1010, 2'd1, "rst_prio");

`ifdef BUS_SCHEDULER_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run_xfer(4'b0001, 2'd0, "stat_a");
    run_xfer(4'b0010, 2'd1, "stat_b");
    run_xfer(4'b0100, 2'd2, "stat_c");
    check_eq("stat_count3", bus_if.xfer_count, 16'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("stat_count_reset", bus_if.xfer_count, 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
